// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered main-decode stage between fetch and execute.
// Decodes a 5-bit opcode into the datapath control bundle, holds it in a
// one-entry valid/ready output register, stalls on load-use hazards against
// the held instruction, honours an execute-stage flush and counts hazard stalls.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to halt intake after an
// illegal opcode until flush or reset.
module decode_ctrl_pipe #(
  parameter int unsigned OP_W   = 5,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              regwrite,
  output logic              memwrite,
  output logic              memread,
  output logic              alumuxen1,
  output logic              alumuxen2,
  output logic              alumuxsel1,
  output logic              alumuxsel2,
  output logic [1:0]        d_dmuxsel,
  output logic              resultsel,
  output logic [1:0]        selr,
  output logic              branch,
  output logic              jump,
  output logic [2:0]        aluop,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  input  logic              flush,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q;
  logic [16:0] dec_ctl;
  logic        dec_illegal;
  logic        use_rs1;
  logic        use_rs2;
  logic        opc_hi;
  logic        rs_match;
  logic        hazard;
  logic        accept;

  // Any set bit above the 5-bit opcode field makes the instruction illegal
  if (OP_W > 5) begin : g_wide_op
    assign opc_hi = |in_opcode[OP_W-1:5];
  end else begin : g_narrow_op
    assign opc_hi = 1'b0;
  end

  // Main decode; bundle order is regwrite,memwrite,memread,en1,en2,sel1,sel2,
  // d_dmuxsel,resultsel,selr,branch,jump,aluop
  always_comb begin
    dec_ctl     = '0;
    dec_illegal = 1'b0;
    use_rs1     = 1'b1;
    use_rs2     = 1'b0;
    case (in_opcode[4:0])
      5'b01101: begin dec_ctl = 17'b1_0_0_1_1_0_0_00_0_00_0_0_010; use_rs2 = 1'b1; end // R4
      5'b00011: begin dec_ctl = 17'b1_0_0_1_0_0_0_00_0_00_0_0_100; use_rs2 = 1'b1; end // R3
      5'b00001: dec_ctl = 17'b1_0_0_0_0_0_0_00_0_00_0_0_110;                            // R2
      5'b00101: dec_ctl = 17'b1_0_0_0_0_0_0_00_0_01_0_0_000;                            // MOV
      5'b10111: dec_ctl = 17'b1_0_1_0_1_0_1_01_1_00_0_0_011;                            // LW
      5'b10001: begin dec_ctl = 17'b0_1_0_0_1_0_1_10_0_00_0_0_011; use_rs2 = 1'b1; end // SW
      5'b01010: begin dec_ctl = 17'b0_0_0_1_0_0_0_00_0_00_1_0_110; use_rs2 = 1'b1; end // BR
      5'b11101: dec_ctl = 17'b1_0_0_0_1_0_1_00_0_00_0_0_111;                            // I
      5'b01111: dec_ctl = 17'b1_0_0_0_1_0_1_10_0_11_0_1_010;                            // JALR
      5'b11110: begin dec_ctl = 17'b1_0_0_0_0_0_0_00_0_11_0_1_010; use_rs1 = 1'b0; end // JAL
      default: begin
        dec_illegal = 1'b1;
        use_rs1     = 1'b0;
      end
    endcase
    if (opc_hi) begin
      dec_ctl     = '0;
      dec_illegal = 1'b1;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
    end
  end

  // Load-use hazard against the held instruction and the fetch-side ready
  always_comb begin
    rs_match = (use_rs1 && (in_rs1 == out_rd)) || (use_rs2 && (in_rs2 == out_rd));
    hazard   = out_valid && memread && (out_rd != '0) && rs_match;
    in_ready = (!out_valid || out_ready) && !hazard && !flush && (state_q == StRun);
  end

  assign accept = in_valid && in_ready;

  // Output register, run/halt state and saturating hazard-stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      out_valid <= 1'b0;
      {regwrite, memwrite, memread, alumuxen1, alumuxen2, alumuxsel1, alumuxsel2,
       d_dmuxsel, resultsel, selr, branch, jump, aluop} <= '0;
      illegal   <= 1'b0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        state_q   <= StRun;
      end else if (accept) begin
        out_valid <= 1'b1;
        {regwrite, memwrite, memread, alumuxen1, alumuxen2, alumuxsel1, alumuxsel2,
         d_dmuxsel, resultsel, selr, branch, jump, aluop} <= dec_ctl;
        illegal   <= dec_illegal;
        out_rd    <= in_rd;
        out_rs1   <= in_rs1;
        out_rs2   <= in_rs2;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (dec_illegal) state_q <= StHalt;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Hazard is the stall cause even under backpressure; flush takes precedence
      if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered main-decode stage for the 5-bit-opcode RISC core, sitting between fetch and execute. It converts each accepted instruction's opcode into the full datapath control bundle. It holds the result in a one-entry valid/ready output register and detects load-use hazards against the instruction it holds. It honours an execute-stage flush and keeps a saturating stall counter.

## Interface
- OP_W, 5: opcode width; opcode occupies bits [4:0], any set bit above [4:0] makes the instruction illegal; must be ≥5
- REG_AW, 5: register-address width
- CNT_W, 16: stall-counter width
- clk in 1: sole clock, all state updates on rising edge
- rst_n in 1: synchronous, active-low reset
- in_valid in 1 / in_ready out 1: fetch handshake; transfer when both high
- in_opcode in OP_W; in_rd, in_rs1, in_rs2 in REG_AW each: instruction fields
- out_valid out 1 / out_ready in 1: execute handshake
- regwrite, memwrite, memread, alumuxen1, alumuxen2, alumuxsel1, alumuxsel2, resultsel, branch, jump out 1 each; d_dmuxsel out 2; selr out 2; aluop out 3: registered control bundle
- out_rd, out_rs1, out_rs2 out REG_AW each: registered fields
- flush in 1: discard held instruction (branch/jump redirect)
- illegal out 1: held instruction had an undefined opcode
- stall_cnt out CNT_W: cycles where in_valid=1 and in_ready=0 due to hazard, saturating

## Operation
Decode values as regwrite,memwrite,memread,en1,en2,sel1,sel2,d_dmuxsel,resultsel,selr,branch,jump,aluop:
- 01101 R4: 1,0,0,1,1,0,0,00,0,00,0,0,010
- 00011 R3: 1,0,0,1,0,0,0,00,0,00,0,0,100
- 00001 R2: 1,0,0,0,0,0,0,00,0,00,0,0,110
- 00101 MOV: 1,0,0,0,0,0,0,00,0,01,0,0,000
- 10111 LW: 1,0,1,0,1,0,1,01,1,00,0,0,011
- 10001 SW: 0,1,0,0,1,0,1,10,0,00,0,0,011
- 01010 BR: 0,0,0,1,0,0,0,00,0,00,1,0,110
- 11101 I: 1,0,0,0,1,0,1,00,0,00,0,0,111
- 01111 JALR: 1,0,0,0,1,0,1,10,0,11,0,1,010
- 11110 JAL: 1,0,0,0,0,0,0,00,0,11,0,1,010
- any other: all zero, illegal=1

Operand use:
- rs1 is used by every legal opcode except JAL.
- rs2 is used by R4, R3, SW and BR.

Hazard:
- Hazard is asserted when out_valid, held memread=1, out_rd≠0, and out_rd equals a used rs of the input.
- in_ready = (!out_valid | out_ready) & !hazard & !flush & state==RUN.
- While the hazard holds, the input waits. Once execute takes the LW, the output register empties, giving exactly one bubble, and the instruction is then accepted.

States:
- RUN: normal operation.
- HALT: exists only with trap enabled (see Configuration).

## Timing
- Reset (rst_n=0 at edge): out_valid=0, all control outputs 0, out_rd/rs1/rs2=0, illegal=0, stall_cnt=0, state=RUN.
- Latency: an instruction accepted at edge N has out_valid=1 after edge N. Throughput is 1 per cycle with no hazard.
- Output register:
  - Holds all values stable while out_valid & !out_ready.
  - Loads on accept.
  - Clears out_valid when consumed with no new accept.
- flush=1 at an edge: out_valid←0, no accept that cycle, state←RUN. Flush overrides a simultaneous accept and the hazard.
- stall_cnt increments only for hazard-caused stalls, and holds at 2^CNT_W−1.
- Reset mid-transfer drops the held instruction; no partial state survives.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - An illegal opcode is captured with illegal=1 and the FSM enters HALT.
  - In HALT, in_ready=0 until flush or reset.
- DECODE_ILLEGAL_TRAP_EN undefined:
  - An illegal opcode passes as an all-zero NOP with illegal=1 for that entry.
  - The pipeline keeps running and HALT is unreachable.

## Test plan
- Reset, then R4 (01101) with out_ready=1 -> next cycle out_valid=1, regwrite=1, en1=en2=1, aluop=010, illegal=0.
- LW rd=3 followed by R3 rs1=3 -> in_ready=0 one cycle, stall_cnt=1, R3 emerges one cycle after LW with one bubble; repeating with rd=0 gives no stall.
- out_ready=0 for 3 cycles with SW held -> outputs stable (memwrite=1, d_dmuxsel=10), in_ready=0; release -> next instruction issues the following cycle.
- BR held, flush=1 with in_valid=1 -> out_valid=0 next cycle, input not accepted that cycle.
- Opcode 00000 -> illegal=1, controls zero; with DECODE_ILLEGAL_TRAP_EN, in_ready stays 0 until flush, then resumes.
- rst_n=0 while JAL is held with out_ready=0 -> out_valid=0, selr=00, jump=0 after the edge.
